// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : MEM-stage sequencer turning a load/store into a req/ack memory
//            transaction, with pipeline stall, load/store formatting and faults.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              wb_bubble,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [2:0]        size_q;
    logic [1:0]        off_q;
    logic              is_load_q;

    logic              access;
    logic              illegal;
    logic              misaligned;
    logic              fault;
    logic [3:0]        st_be;
    logic [DATA_W-1:0] st_wdata;

    function automatic logic [DATA_W-1:0] fmt_load(input logic [2:0] f,
                                                   input logic [1:0] off,
                                                   input logic [DATA_W-1:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = d[{off[1], 4'b0000} +: 16];
        case (f)
            3'b000:  fmt_load = {{(DATA_W-8){b[7]}}, b};
            3'b001:  fmt_load = {{(DATA_W-16){h[15]}}, h};
            3'b100:  fmt_load = {{(DATA_W-8){1'b0}}, b};
            3'b101:  fmt_load = {{(DATA_W-16){1'b0}}, h};
            default: fmt_load = d;
        endcase
    endfunction

    assign access     = mem_read | mem_write;
    assign illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    assign misaligned = (((funct3 == 3'b001) || (funct3 == 3'b101)) && addr[0]) ||
                        ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
    assign fault      = illegal | misaligned;
    assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // Gating with rst makes the pipeline release in the same cycle reset hits.
    assign stall     = !rst && (((state == IDLE) && access) || (state == WAIT));
    assign wb_bubble = stall;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {(DATA_W/8){wdata[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << addr[1:0];
                st_wdata = {(DATA_W/16){wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            size_q     <= '0;
            off_q      <= '0;
            is_load_q  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    err        <= 1'b0;
                    load_valid <= 1'b0;
                    cnt        <= '0;
                    if (access) begin
                        is_load_q <= mem_read;
                        size_q    <= funct3;
                        off_q     <= addr[1:0];
                        if (fault) begin
                            err        <= 1'b1;
                            load_data  <= '0;
                            load_valid <= mem_read;
                            state      <= DONE;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= mem_write;
                            mem_be    <= mem_write ? st_be : 4'b1111;
                            mem_addr  <= {addr[DATA_W-1:2], 2'b00};
                            mem_wdata <= mem_write ? st_wdata : '0;
                            state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt_inc;
                    // Ack is checked first so a last-cycle ack beats the timeout.
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        load_data  <= fmt_load(size_q, off_q, mem_rdata);
                        load_valid <= is_load_q;
                        state      <= DONE;
                    end else if (cnt_inc == CNT_MAX) begin
                        mem_req    <= 1'b0;
                        load_data  <= '0;
                        load_valid <= is_load_q;
                        err        <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    err        <= 1'b0;
                    load_valid <= 1'b0;
                    cnt        <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Directed self-checking bench for mem_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall, wb_bubble;
    logic [31:0] load_data;
    logic        load_valid, err;

    int total = 0;
    int bad   = 0;

    int          st_cnt, wb_cnt, rq_cnt;
    logic        r_err, r_lv, r_we;
    logic [31:0] r_ld, r_addr, r_wd;
    logic [3:0]  r_be;

    mem_access_ctrl #(.DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .wb_bubble(wb_bubble),
        .load_data(load_data), .load_valid(load_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one access from an IDLE cycle through DONE; memory acks in WAIT cycle ackc (0 = never).
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ackc, input logic [31:0] rdat);
        int reqs;
        bit done;
        reqs = 0; done = 0; st_cnt = 0; wb_cnt = 0;
        r_err = 1'bx; r_lv = 1'bx; r_ld = 'x;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        for (int i = 0; i < 40 && !done; i++) begin
            mem_ack   = mem_req && ((reqs + 1) == ackc);
            mem_rdata = mem_req ? rdat : 32'hDEAD_BEEF;
            @(negedge clk);
            if (wb_bubble) wb_cnt++;
            if (!stall) begin
                done  = 1;
                r_err = err; r_lv = load_valid; r_ld = load_data;
            end else begin
                st_cnt++;
                if (mem_req) begin
                    reqs++;
                    r_addr = mem_addr; r_be = mem_be; r_wd = mem_wdata; r_we = mem_we;
                end
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        rq_cnt = reqs;
        mem_read = 1'b0; mem_write = 1'b0;
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_load_valid", {31'd0, load_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Non-memory traffic with stray acks.
        for (int i = 0; i < 10; i++) begin
            mem_ack = (i == 3) || (i == 7);
            mem_rdata = 32'h1234_0000 + i;
            @(negedge clk);
            chk("idle_stall", {31'd0, stall}, 32'd0);
            chk("idle_bubble", {31'd0, wb_bubble}, 32'd0);
            chk("idle_req", {31'd0, mem_req}, 32'd0);
            @(posedge clk); #1;
        end
        mem_ack = 0;

        // LB 0x1003, ack in first WAIT cycle
        run_access(1, 0, 3'b000, 32'h1003, 32'h0, 1, 32'h80AA_BBCC);
        chk("lb_addr", r_addr, 32'h1000);
        chk("lb_be", {28'd0, r_be}, 32'h0000_000F);
        chk("lb_we", {31'd0, r_we}, 32'd0);
        chk("lb_stalls", st_cnt, 32'd2);
        chk("lb_bubbles", wb_cnt, 32'd2);
        chk("lb_reqs", rq_cnt, 32'd1);
        chk("lb_data", r_ld, 32'hFFFF_FF80);
        chk("lb_valid", {31'd0, r_lv}, 32'd1);
        chk("lb_err", {31'd0, r_err}, 32'd0);

        // SH 0x2002, ack after 3 cycles (back-to-back with LB)
        run_access(0, 1, 3'b001, 32'h2002, 32'h1234_5678, 3, 32'h0);
        chk("sh_be", {28'd0, r_be}, 32'h0000_000C);
        chk("sh_wdata", r_wd, 32'h5678_5678);
        chk("sh_we", {31'd0, r_we}, 32'd1);
        chk("sh_addr", r_addr, 32'h2000);
        chk("sh_stalls", st_cnt, 32'd4);
        chk("sh_valid", {31'd0, r_lv}, 32'd0);
        chk("sh_err", {31'd0, r_err}, 32'd0);

        // SB 0x0005
        run_access(0, 1, 3'b000, 32'h0005, 32'hFFFF_FFAB, 1, 32'h0);
        chk("sb_be", {28'd0, r_be}, 32'h0000_0002);
        chk("sb_wdata", r_wd, 32'hABAB_ABAB);

        // Misaligned LW then LHU 0x0006
        run_access(1, 0, 3'b010, 32'h0001, 32'h0, 1, 32'h5555_5555);
        chk("lwmis_stalls", st_cnt, 32'd1);
        chk("lwmis_reqs", rq_cnt, 32'd0);
        chk("lwmis_err", {31'd0, r_err}, 32'd1);
        chk("lwmis_data", r_ld, 32'd0);
        run_access(1, 0, 3'b101, 32'h0006, 32'h0, 2, 32'hBEEF_1234);
        chk("lhu_data", r_ld, 32'h0000_BEEF);
        chk("lhu_stalls", st_cnt, 32'd3);
        chk("lhu_err", {31'd0, r_err}, 32'd0);

        // Other faults
        run_access(1, 0, 3'b011, 32'h0000, 32'h0, 1, 32'h0);
        chk("illegal_err", {31'd0, r_err}, 32'd1);
        chk("illegal_reqs", rq_cnt, 32'd0);
        run_access(0, 1, 3'b001, 32'h0003, 32'h0, 1, 32'h0);
        chk("shmis_err", {31'd0, r_err}, 32'd1);
        chk("shmis_stalls", st_cnt, 32'd1);

        // LH sign extension, LBU zero extension
        run_access(1, 0, 3'b001, 32'h0002, 32'h0, 1, 32'h8001_7FFF);
        chk("lh_data", r_ld, 32'hFFFF_8001);
        run_access(1, 0, 3'b100, 32'h0001, 32'h0, 1, 32'h0000_9A00);
        chk("lbu_data", r_ld, 32'h0000_009A);

        // Timeout, then ack on the last allowed cycle
        run_access(1, 0, 3'b010, 32'h3000, 32'h0, 0, 32'hFFFF_FFFF);
        chk("to_reqs", rq_cnt, 32'd16);
        chk("to_stalls", st_cnt, 32'd17);
        chk("to_err", {31'd0, r_err}, 32'd1);
        chk("to_data", r_ld, 32'd0);
        run_access(1, 0, 3'b010, 32'h3004, 32'h0, 16, 32'hCAFE_F00D);
        chk("ack16_reqs", rq_cnt, 32'd16);
        chk("ack16_err", {31'd0, r_err}, 32'd0);
        chk("ack16_data", r_ld, 32'hCAFE_F00D);

        // Reset mid-WAIT
        mem_read = 1; funct3 = 3'b010; addr = 32'h4000;
        repeat (3) begin @(posedge clk); end
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_bubble", {31'd0, wb_bubble}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        mem_read = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_access(1, 0, 3'b010, 32'h4008, 32'h0, 2, 32'h1122_3344);
        chk("postrst_data", r_ld, 32'h1122_3344);
        chk("postrst_err", {31'd0, r_err}, 32'd0);
        chk("postrst_stalls", st_cnt, 32'd3);
        chk("postrst_addr", r_addr, 32'h4008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
